// File: rtl/serial_pkg.sv
// Shared definitions for the piso_tx / sipo serial link.
package serial_pkg;

    // Default word width shared by both ends of the link.
    localparam int unsigned SERIAL_WIDTH = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    // Bit-counter width for a given word width (never narrower than 1).
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_hold_reg.sv
// One-entry holding register: lets the next word be accepted mid-frame.
module piso_hold_reg
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = SERIAL_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             full_o,
    output logic [WIDTH-1:0] data_o
);

    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Load only happens while empty and pop only while full, so they never coincide.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (load_i) begin
            full_d = 1'b1;
            data_d = din_i;
        end else if (pop_i) begin
            full_d = 1'b0;
        end
    end

    // Holding register state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with frame markers and a one-word skid buffer.
module piso_tx
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH     = SERIAL_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_first,
    output logic             frame_last,
    output logic             busy
);

    localparam int unsigned        CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH - 1);

    piso_state_t      state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] shifted;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hold_full, hold_load, hold_pop;
    logic [WIDTH-1:0] hold_data;
    logic             accept, last_bit;

    assign load_ready = !hold_full;
    assign accept     = load_valid && load_ready;
    assign last_bit   = (cnt_q == LAST_CNT);
    assign shifted    = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};

    piso_hold_reg #(.WIDTH(WIDTH)) u_hold (
        .clk    (clk),
        .rst    (rst),
        .load_i (hold_load),
        .pop_i  (hold_pop),
        .din_i  (din),
        .full_o (hold_full),
        .data_o (hold_data)
    );

    // Next-state: frame start, shifting, handoff from hold / pass-through, and frame end.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        hold_load = 1'b0;
        hold_pop  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d = din;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_en && last_bit) begin
                    cnt_d = '0;
                    if (hold_full) begin
                        shreg_d  = hold_data;
                        hold_pop = 1'b1;
                    end else if (accept) begin
                        shreg_d = din;
                    end else begin
                        // Clearing the shifter keeps dout low while idle.
                        shreg_d = '0;
                        state_d = IDLE;
                    end
                end else begin
                    if (shift_en) begin
                        shreg_d = shifted;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                    hold_load = accept;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shifter, bit counter and state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout        = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign dout_valid  = (state_q == SHIFT);
    assign frame_first = dout_valid && (cnt_q == '0);
    assign frame_last  = dout_valid && last_bit;
    assign busy        = dout_valid || hold_full;

endmodule
